pll_digital_loop_filter: RTL and testbench

Digital proportional-integral loop filter for the all-digital PLL. It sits directly downstream of the phase frequency detector and consumes its `up`/`down` pulses, which are synchronous to `clk`. Each pulse's width is measured in `clk` cycles, and the result is turned into a signed phase error. A PI update then produces a saturated control word for the DCO, plus a lock indicator.

---
 rtl/pll_digital_loop_filter.sv | 157 +++++++++++++++
 tb/tb_pll_digital_loop_filter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_digital_loop_filter.sv
// PI loop filter for the all-digital PLL: measures PFD up/down pulse widths in clk
// cycles and turns each one into a saturated DCO control word plus a lock flag.
module pll_digital_loop_filter #(
  parameter int                    CW_WIDTH   = 16,
  parameter logic [CW_WIDTH-1:0]   CW_INIT    = 16'h8000,
  parameter int                    PW_WIDTH   = 8,
  parameter int                    INT_WIDTH  = 20,
  parameter int                    KP_SHIFT   = 2,
  parameter int                    KI_SHIFT   = 4,
  parameter int                    LOCK_TOL   = 1,
  parameter int                    LOCK_COUNT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                up,
  input  logic                down,
  output logic [CW_WIDTH-1:0] ctrl_word,
  output logic                ctrl_valid,
  output logic                sat_hi,
  output logic                sat_lo,
  output logic                lock
);

  localparam int SUM_W = ((CW_WIDTH > INT_WIDTH) ? CW_WIDTH : INT_WIDTH) + PW_WIDTH + KP_SHIFT + 2;
  localparam int ERR_W = PW_WIDTH + 1;
  localparam int LC_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [ERR_W-1:0] TOL    = ERR_W'(LOCK_TOL);
  localparam logic [LC_W-1:0]  LC_MAX = LC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, MEAS_UP, MEAS_DN, UPDATE} state_t;

  state_t                      state, state_nxt;
  logic [PW_WIDTH-1:0]         count, count_nxt;
  logic signed [ERR_W-1:0]     err, err_nxt;
  logic signed [INT_WIDTH-1:0] integ, integ_new, integ_shr;
  logic signed [INT_WIDTH:0]   integ_sum, err_i;
  logic signed [SUM_W-1:0]     cw_init_ext, err_ext, kp_term, ki_term, ctrl_sum;
  logic [ERR_W-1:0]            err_mag;
  logic [LC_W-1:0]             lock_cnt, lock_cnt_new;
  logic [CW_WIDTH-1:0]         cw_new;
  logic                        hi_new, lo_new;
  logic                        do_update, up_only, dn_only;

  assign up_only = up & ~down;
  assign dn_only = down & ~up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // UPDATE also acts as IDLE for the next pulse, so an edge arriving there is not lost.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    err_nxt   = err;
    do_update = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, UPDATE: begin
          do_update = (state == UPDATE);
          if (up_only) begin
            state_nxt = MEAS_UP;
            count_nxt = PW_WIDTH'(1);
          end else if (dn_only) begin
            state_nxt = MEAS_DN;
            count_nxt = PW_WIDTH'(1);
          end else begin
            state_nxt = IDLE;
          end
        end
        MEAS_UP: begin
          if (up_only) begin
            count_nxt = (count == '1) ? count : count + 1'b1;
          end else begin
            err_nxt   = $signed({1'b0, count});
            state_nxt = UPDATE;
          end
        end
        MEAS_DN: begin
          if (dn_only) begin
            count_nxt = (count == '1) ? count : count + 1'b1;
          end else begin
            err_nxt   = -$signed({1'b0, count});
            state_nxt = UPDATE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    err_i     = {{(INT_WIDTH + 1 - ERR_W){err[ERR_W-1]}}, err};
    integ_sum = {integ[INT_WIDTH-1], integ} + err_i;
    // One guard bit is enough: overflow shows as a mismatch between the top two bits.
    if (integ_sum[INT_WIDTH] != integ_sum[INT_WIDTH-1])
      integ_new = integ_sum[INT_WIDTH] ? {1'b1, {(INT_WIDTH-1){1'b0}}} : {1'b0, {(INT_WIDTH-1){1'b1}}};
    else
      integ_new = integ_sum[INT_WIDTH-1:0];

    integ_shr   = integ_new >>> KI_SHIFT;
    cw_init_ext = {{(SUM_W - CW_WIDTH){1'b0}}, CW_INIT};
    err_ext     = {{(SUM_W - ERR_W){err[ERR_W-1]}}, err};
    kp_term     = err_ext <<< KP_SHIFT;
    ki_term     = {{(SUM_W - INT_WIDTH){integ_shr[INT_WIDTH-1]}}, integ_shr};
    ctrl_sum    = cw_init_ext + kp_term + ki_term;

    hi_new = 1'b0;
    lo_new = 1'b0;
    if (ctrl_sum[SUM_W-1]) begin
      cw_new = '0;
      lo_new = 1'b1;
    end else if (ctrl_sum[SUM_W-2:CW_WIDTH] != '0) begin
      cw_new = '1;
      hi_new = 1'b1;
    end else begin
      cw_new = ctrl_sum[CW_WIDTH-1:0];
    end

    err_mag = err[ERR_W-1] ? -err : err;
    if (err_mag <= TOL)
      lock_cnt_new = (lock_cnt == LC_MAX) ? lock_cnt : lock_cnt + 1'b1;
    else
      lock_cnt_new = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      err        <= '0;
      integ      <= '0;
      lock_cnt   <= '0;
      ctrl_word  <= CW_INIT;
      ctrl_valid <= 1'b0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
      lock       <= 1'b0;
    end else begin
      count      <= count_nxt;
      err        <= err_nxt;
      ctrl_valid <= do_update;
      if (do_update) begin
        integ     <= integ_new;
        lock_cnt  <= lock_cnt_new;
        ctrl_word <= cw_new;
        sat_hi    <= hi_new;
        sat_lo    <= lo_new;
        lock      <= (lock_cnt_new == LC_MAX);
      end
    end
  end

endmodule

// File: tb/tb_pll_digital_loop_filter.sv
// Bench for pll_digital_loop_filter: a default instance plus a narrow-integrator instance
// (so both clamps are reachable quickly), both checked every cycle against a pulse-level model.
module tb_pll_digital_loop_filter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic up = 1'b0;
  logic down = 1'b0;

  logic [15:0] a_cw;
  logic        a_valid, a_hi, a_lo, a_lock;
  logic [9:0]  b_cw;
  logic        b_valid, b_hi, b_lo, b_lock;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int vcount = 0;
  int waited;

  always #5 clk = ~clk;

  pll_digital_loop_filter u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .down(down),
    .ctrl_word(a_cw), .ctrl_valid(a_valid), .sat_hi(a_hi), .sat_lo(a_lo), .lock(a_lock)
  );

  pll_digital_loop_filter #(.CW_WIDTH(10), .CW_INIT(10'h200), .INT_WIDTH(12)) u_small (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .down(down),
    .ctrl_word(b_cw), .ctrl_valid(b_valid), .sat_hi(b_hi), .sat_lo(b_lo), .lock(b_lock)
  );

  // Model parameters per instance: [0] default, [1] small.
  int p_init[2]  = '{32768, 512};
  int p_cwmax[2] = '{65535, 1023};
  int p_imax[2]  = '{524287, 2047};
  int p_imin[2]  = '{-524288, -2048};

  int m_dir = 0, m_len = 0, m_err = 0, m_lockc = 0;
  bit m_pend = 1'b0;
  int m_integ[2] = '{0, 0};
  int e_cw[2]    = '{32768, 512};
  bit e_hi[2]    = '{1'b0, 1'b0};
  bit e_lo[2]    = '{1'b0, 1'b0};
  bit e_valid = 1'b0, e_lock = 1'b0;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dir = 0; m_len = 0; m_err = 0; m_pend = 1'b0; m_lockc = 0;
    e_valid = 1'b0; e_lock = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_integ[k] = 0; e_cw[k] = p_init[k]; e_hi[k] = 1'b0; e_lo[k] = 1'b0;
    end
  endtask

  task automatic model_apply(input int e);
    int s;
    e_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_integ[k] = clampi(m_integ[k] + e, p_imin[k], p_imax[k]);
      s = p_init[k] + e * 4 + (m_integ[k] >>> 4);
      e_hi[k] = (s > p_cwmax[k]);
      e_lo[k] = (s < 0);
      e_cw[k] = clampi(s, 0, p_cwmax[k]);
    end
    m_lockc = (e >= -1 && e <= 1) ? ((m_lockc < 8) ? m_lockc + 1 : 8) : 0;
    e_lock  = (m_lockc == 8);
  endtask

  // Pulse-level model: a pulse closes on the first sample that is not "this direction only";
  // its update lands one edge later, and that edge may also open the next pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      e_valid = 1'b0;
      if (!enable) begin
        m_dir = 0; m_pend = 1'b0;
      end else if (m_dir != 0) begin
        if ((m_dir > 0) ? (up && !down) : (down && !up))
          m_len = (m_len < 255) ? m_len + 1 : 255;
        else begin
          m_err = m_dir * m_len; m_pend = 1'b1; m_dir = 0;
        end
      end else begin
        if (m_pend) begin
          model_apply(m_err); m_pend = 1'b0;
        end
        if (up != down) begin
          m_dir = up ? 1 : -1; m_len = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      cmp("a_ctrl_word",  int'(a_cw),    e_cw[0]);
      cmp("a_ctrl_valid", int'(a_valid), int'(e_valid));
      cmp("a_sat_hi",     int'(a_hi),    int'(e_hi[0]));
      cmp("a_sat_lo",     int'(a_lo),    int'(e_lo[0]));
      cmp("a_lock",       int'(a_lock),  int'(e_lock));
      cmp("b_ctrl_word",  int'(b_cw),    e_cw[1]);
      cmp("b_ctrl_valid", int'(b_valid), int'(e_valid));
      cmp("b_sat_hi",     int'(b_hi),    int'(e_hi[1]));
      cmp("b_sat_lo",     int'(b_lo),    int'(e_lo[1]));
      cmp("b_lock",       int'(b_lock),  int'(e_lock));
    end
  end

  always @(posedge clk) begin
    #1;
    if (a_valid) vcount++;
  end

  task automatic drive(input bit u, input bit d, input bit en, input int n);
    up = u; down = d; enable = en;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(output int w);
    w = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w = i + 1;
      if (a_valid) return;
    end
    checks++; errors++;
    $display("FAIL wait_valid: got no ctrl_valid within 8 cycles, expected one (t=%0t)", $time);
    w = -1;
  endtask

  task automatic pulse(input bit is_up, input int n, output int w);
    drive(is_up, !is_up, 1'b1, n);
    up = 1'b0; down = 1'b0;
    wait_valid(w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; up = 1'b0; down = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    cmp("reset_cw", int'(a_cw), 32'h8000);
    cmp("reset_valid", int'(a_valid), 0);
    cmp("reset_lock", int'(a_lock), 0);
    cmp("reset_sat", int'({a_hi, a_lo}), 0);

    // Basic PI update
    pulse(1'b1, 5, waited);
    cmp("basic_latency", waited, 2);
    cmp("basic_up5_cw", int'(a_cw), 32'h8014);
    cmp("model_up5_cw", e_cw[0], 32'h8014);
    cmp("small_up5_cw", int'(b_cw), 532);
    pulse(1'b0, 3, waited);
    cmp("basic_dn3_cw", int'(a_cw), 32'h7FF4);
    cmp("small_dn3_cw", int'(b_cw), 500);

    // Counter saturation and upper clamp
    do_reset();
    pulse(1'b1, 300, waited);
    cmp("sat300_cw", int'(a_cw), 32'h840B);
    cmp("model_sat300_cw", e_cw[0], 32'h840B);
    cmp("small_sat300_hi", int'({b_hi, b_cw}), 2047);
    for (int i = 0; i < 10; i++) pulse(1'b1, 255, waited);
    cmp("up11_cw", int'(a_cw), 32'h84AB);
    cmp("small_up11_hi", int'({b_hi, b_cw}), 2047);
    pulse(1'b0, 100, waited);
    cmp("dn100_cw", int'(a_cw), 32'h7F19);
    cmp("small_dn100_cw", int'(b_cw), 233);
    cmp("small_dn100_sat", int'({b_hi, b_lo}), 0);

    // Lower clamp
    for (int i = 0; i < 20; i++) pulse(1'b0, 255, waited);
    cmp("dn20_cw", int'(a_cw), 32'h7B6E);
    cmp("small_lo_cw", int'(b_cw), 0);
    cmp("small_lo_flag", int'(b_lo), 1);
    pulse(1'b1, 100, waited);
    cmp("up100_cw", int'(a_cw), 32'h8100);
    cmp("small_integ_clamp_cw", int'(b_cw), 790);
    cmp("model_integ_clamp_cw", e_cw[1], 790);

    // Lock acquisition and loss
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pulse((i % 2) == 0, 1, waited);
      cmp("lock_step", int'(a_lock), int'(i == 7));
    end
    pulse(1'b1, 4, waited);
    cmp("lock_loss", int'(a_lock), 0);
    cmp("lock_loss_cw", int'(a_cw), 32'h8010);

    // Both high in IDLE
    do_reset();
    vcount = 0;
    drive(1'b1, 1'b1, 1'b1, 3);
    drive(1'b0, 1'b0, 1'b1, 3);
    cmp("both_high_valids", vcount, 0);

    // Down pulse opening in the UPDATE cycle of an up pulse
    drive(1'b1, 1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 1'b1, 1);
    down = 1'b1;
    @(negedge clk);
    cmp("b2b_first_valid", int'(a_valid), 1);
    cmp("b2b_first_cw", int'(a_cw), 32'h800C);
    repeat (3) @(negedge clk);
    down = 1'b0;
    wait_valid(waited);
    cmp("b2b_latency", waited, 2);
    cmp("b2b_second_cw", int'(a_cw), 32'h7FEF);

    // Enable dropped mid-pulse, then re-enabled under a high pulse
    vcount = 0;
    drive(1'b1, 1'b0, 1'b1, 3);
    drive(1'b1, 1'b0, 1'b0, 2);
    drive(1'b0, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b1, 3);
    cmp("enable_valids", vcount, 0);
    cmp("enable_hold_cw", int'(a_cw), 32'h7FEF);
    drive(1'b1, 1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 1'b1, 2);
    up = 1'b0;
    wait_valid(waited);
    cmp("reenable_cw", int'(a_cw), 32'h8008);

    // Asynchronous reset mid-measurement
    drive(1'b1, 1'b0, 1'b1, 3);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_cw", int'(a_cw), 32'h8000);
    cmp("async_flags", int'({a_valid, a_hi, a_lo, a_lock}), 0);
    cmp("async_small_cw", int'(b_cw), 512);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (31) @(negedge clk);
    up = 1'b0;
    wait_valid(waited);
    cmp("post_reset_cw", int'(a_cw), 32'h807D);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
